// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding and port indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Winner selection for the memory arbiter; MEM_ARB_ROUND_ROBIN_EN selects round-robin
// tie-breaking, otherwise port A has fixed priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic last_gnt,
    input  logic locked,
    input  logic owner,
    output logic winner
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

    always_comb begin
        winner = PORT_A;
        if (locked) begin
            winner = owner;
        end else if (a_req && b_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            winner = (last_gnt == PORT_A) ? PORT_B : PORT_A;
`else
            winner = PORT_A;
`endif
        end else if (b_req) begin
            winner = PORT_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing a single-port synchronous memory between masters A and B,
// with lock support. Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic                  a_lock,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic                  b_lock,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  a_ack,
    output logic                  b_ack,
    output logic                  a_gnt,
    output logic                  b_gnt,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] mem,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  busy
);

    arb_state_e            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  own_q, own_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  winner;
    logic                  win_req;
    logic                  owner_lock;

    // own_q is only ever set in IDLE while a lock is held, so it doubles as the lock flag there
    arb_pick u_pick (
        .a_req    (a_req),
        .b_req    (b_req),
        .last_gnt (last_q),
        .locked   (own_q),
        .owner    (owner_q),
        .winner   (winner)
    );

    assign win_req    = (winner == PORT_A) ? a_req : b_req;
    assign owner_lock = (owner_q == PORT_A) ? a_lock : b_lock;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        own_d      = own_q;
        last_d     = last_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (win_req) begin
                    state_d    = ACCESS;
                    owner_d    = winner;
                    own_d      = 1'b1;
                    last_d     = winner;
                    mem_addr_d = (winner == PORT_A) ? a_addr  : b_addr;
                    mem_data_d = (winner == PORT_A) ? a_wdata : b_wdata;
                    mem_we_d   = (winner == PORT_A) ? a_we    : b_we;
                end
            end
            ACCESS: state_d = mem_we_q ? ACK : WAIT;
            WAIT: begin
                rdata_d = mem;
                state_d = ACK;
            end
            ACK: begin
                own_d   = owner_lock;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= PORT_A;
            own_q      <= 1'b0;
            last_q     <= PORT_B;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            own_q      <= own_d;
            last_q     <= last_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            rdata_q    <= rdata_d;
        end
    end

    assign a_ack    = (state_q == ACK) && (owner_q == PORT_A);
    assign b_ack    = (state_q == ACK) && (owner_q == PORT_B);
    assign a_gnt    = own_q && (owner_q == PORT_A);
    assign b_gnt    = own_q && (owner_q == PORT_B);
    assign busy     = (state_q != IDLE);
    assign rdata    = rdata_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_we   = mem_we_q;

endmodule
